// File: rtl/c1541_pkg.sv
// Shared types and helpers for the 1541 drive mechanics: bit-rate zones and
// the track-number boundaries that select them.
package c1541_pkg;

    typedef enum logic [1:0] {
        ZONE_0 = 2'd0,
        ZONE_1 = 2'd1,
        ZONE_2 = 2'd2,
        ZONE_3 = 2'd3
    } zone_t;

    localparam int ZONE3_MAX_TRK = 17;
    localparam int ZONE2_MAX_TRK = 24;
    localparam int ZONE1_MAX_TRK = 30;

    // Outer tracks hold more sectors, so they get the fastest bit-rate zone.
    function automatic zone_t ht_to_zone(input logic [5:0] trk);
        zone_t z;
        if (trk <= 6'(ZONE3_MAX_TRK)) begin
            z = ZONE_3;
        end else if (trk <= 6'(ZONE2_MAX_TRK)) begin
            z = ZONE_2;
        end else if (trk <= 6'(ZONE1_MAX_TRK)) begin
            z = ZONE_1;
        end else begin
            z = ZONE_0;
        end
        return z;
    endfunction

endpackage

// File: rtl/c1541_step_dec.sv
// Stepper phase decoder: compares previous and current VIA phase outputs and
// flags an inward or outward half-track step.
module c1541_step_dec (
    input  logic [1:0] stp_r_i,
    input  logic [1:0] stp_i,
    output logic       inc_o,
    output logic       dec_o
);

    // Phase sequence 0,2,1,3 walks inward; the reverse walks outward.
    // Diagonal jumps and an unchanged phase produce no motion.
    always_comb begin
        inc_o = 1'b0;
        dec_o = 1'b0;
        case ({stp_r_i, stp_i})
            4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: inc_o = 1'b1;
            4'b10_00, 4'b01_10, 4'b11_01, 4'b00_11: dec_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/c1541_head.sv
// Head position and motor stage: half-track stepping, derived track/zone/tr00,
// settle timing, and write-back requests for the dirty track buffer.
module c1541_head
    import c1541_pkg::*;
#(
    parameter int START_HT = 36,
    parameter int MIN_HT   = 1,
    parameter int MAX_HT   = 80,
    parameter int SETTLE   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       act,
    input  logic       buff_we,
    input  logic       disk_change,
    input  logic       busy,
    output logic [5:0] track,
    output logic [6:0] half_track,
    output logic       tr00_sense_n,
    output logic [1:0] zone,
    output logic       head_ready,
    output logic       save_track
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [6:0]    half_track_q, half_track_d;
    logic [5:0]    track_q;
    zone_t         zone_q;
    logic          tr00_n_q;
    logic [1:0]    stp_r_q;
    logic          act_r_q;
    logic          modified_q, modified_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] settle_q, settle_d;

    logic inc, dec, step, trigger, dirty, issue;

    c1541_step_dec u_step_dec (
        .stp_r_i (stp_r_q),
        .stp_i   (stp),
        .inc_o   (inc),
        .dec_o   (dec)
    );

    always_comb begin
        half_track_d = half_track_q;
        modified_d   = modified_q;
        pending_d    = pending_q;
        settle_d     = settle_q;

        step    = mtr & (inc | dec);
        trigger = step | (act_r_q & ~act);
        dirty   = modified_q | buff_we;
        issue   = pending_q & ~busy;

        if (mtr & inc) begin
            half_track_d = (half_track_q >= 7'(MAX_HT)) ? 7'(MAX_HT) : half_track_q + 7'd1;
        end else if (mtr & dec) begin
            half_track_d = (half_track_q <= 7'(MIN_HT)) ? 7'(MIN_HT) : half_track_q - 7'd1;
        end

        // A swapped disk invalidates whatever the buffer holds, so nothing is saved.
        if (disk_change) begin
            modified_d = 1'b0;
            pending_d  = 1'b0;
        end else begin
            pending_d  = (pending_q & ~issue) | (trigger & dirty);
            modified_d = trigger ? 1'b0 : dirty;
        end

        if (step) begin
            settle_d = CW'(SETTLE);
        end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_track_q <= 7'(START_HT);
            track_q      <= 6'(START_HT / 2);
            zone_q       <= ht_to_zone(6'(START_HT / 2));
            tr00_n_q     <= ((START_HT / 2) != 0);
            stp_r_q      <= stp;
            act_r_q      <= act;
            modified_q   <= 1'b0;
            pending_q    <= 1'b0;
            settle_q     <= '0;
        end else if (ce) begin
            half_track_q <= half_track_d;
            track_q      <= half_track_q[6:1];
            zone_q       <= ht_to_zone(half_track_q[6:1]);
            tr00_n_q     <= (half_track_q[6:1] != 6'd0);
            stp_r_q      <= stp;
            act_r_q      <= act;
            modified_q   <= modified_d;
            pending_q    <= pending_d;
            settle_q     <= settle_d;
        end
    end

    // The request is a strobe aligned to the ce tick that clears pending.
    assign save_track   = ce & ~reset & ~disk_change & issue;
    assign half_track   = half_track_q;
    assign track        = track_q;
    assign zone         = zone_q;
    assign tr00_sense_n = tr00_n_q;
    assign head_ready   = (settle_q == '0);

endmodule
